// File: rtl/bcd_to_bin_converter_pkg.sv
// Shared definitions for the decimal-entry path: the converter state
// encoding, the BCD digit geometry and the digit legality test.
package calc_pkg;

    // Width of one packed BCD digit.
    localparam int unsigned DIGIT_W = 4;

    // Largest legal decimal digit value.
    localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

    // Converter sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    // True when a nibble holds a legal decimal digit (0..9).
    function automatic logic is_bcd(input logic [DIGIT_W-1:0] nibble);
        return (nibble <= MAX_DIGIT);
    endfunction

endpackage : calc_pkg

// File: rtl/bcd_to_bin_converter_if.sv
// Request/result bundle between a digit-entry source and the converter.
// The master raises start with the packed digits; the slave returns the
// binary operand together with valid/busy/err status.
interface bcd_to_bin_converter_if
    import calc_pkg::*;
#(
    parameter int unsigned NDIG = 4,
    parameter int unsigned BW   = 14
);

    logic                    start;
    logic [NDIG*DIGIT_W-1:0] bcd_in;
    logic [BW-1:0]           bin_out;
    logic                    valid;
    logic                    busy;
    logic                    err;

    // Requester side: drives the digits and the start request.
    modport master (
        output start,
        output bcd_in,
        input  bin_out,
        input  valid,
        input  busy,
        input  err
    );

    // Converter side: consumes the request and returns the result.
    modport slave (
        input  start,
        input  bcd_in,
        output bin_out,
        output valid,
        output busy,
        output err
    );

endinterface : bcd_to_bin_converter_if

// File: rtl/bcd_to_bin_converter_mul10_add.sv
// One Horner step of decimal-to-binary conversion: acc*10 + digit.
// Purely combinational and width-parameterised so the button-entry path can
// reuse it. The product is formed as (acc<<3)+(acc<<1) four bits wider than
// the accumulator so no intermediate bit is lost, then trimmed back to W.
module mul10_add
    import calc_pkg::*;
#(
    parameter int unsigned W = 14
) (
    input  logic [W-1:0]       acc_i,
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [W-1:0]       sum_o
);

    logic [W+3:0] acc_ext_s;
    logic [W+3:0] acc_x8_s;
    logic [W+3:0] acc_x2_s;
    logic [W+3:0] digit_ext_s;
    logic [W+3:0] total_s;

    // Shift-and-add multiply by ten, then add the incoming digit.
    always_comb begin
        acc_ext_s   = {4'b0000, acc_i};
        acc_x8_s    = acc_ext_s << 3;
        acc_x2_s    = acc_ext_s << 1;
        digit_ext_s = {{W{1'b0}}, digit_i};
        total_s     = acc_x8_s + acc_x2_s + digit_ext_s;
        sum_o       = W'(total_s);
    end

endmodule : mul10_add

// File: rtl/bcd_to_bin_converter.sv
// Sequential BCD-to-binary converter for user-entered decimal operands.
// Digits are consumed most-significant first, one per clock, through the
// mul10_add step. A request with any non-decimal nibble skips the arithmetic
// and reports err with a zero result. All outputs come straight from flops.
module bcd_to_bin_converter
    import calc_pkg::*;
#(
    parameter int unsigned NDIG = 4,
    parameter int unsigned BW   = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_to_bin_converter_if.slave bus
);

    localparam int unsigned SR_W  = NDIG * DIGIT_W;
    localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

    // Sequencer and datapath state.
    state_e            state_q,    state_d;
    logic [SR_W-1:0]   sr_q,       sr_d;
    logic [BW-1:0]     acc_q,      acc_d;
    logic [IDX_W-1:0]  idx_q,      idx_d;
    logic              err_pend_q, err_pend_d;

    // Registered outputs.
    logic [BW-1:0]     bin_out_q,  bin_out_d;
    logic              err_q,      err_d;
    logic              valid_q,    valid_d;
    logic              busy_q,     busy_d;

    // Combinational helpers.
    logic [DIGIT_W-1:0] top_digit_s;
    logic [BW-1:0]      step_sum_s;
    logic               any_bad_s;

    // The digit under conversion is always the top nibble of the shifter.
    assign top_digit_s = sr_q[SR_W-1 -: DIGIT_W];

    mul10_add #(
        .W (BW)
    ) u_mul10_add (
        .acc_i   (acc_q),
        .digit_i (top_digit_s),
        .sum_o   (step_sum_s)
    );

    // Screen every incoming nibble so an illegal request never enters the
    // arithmetic loop.
    always_comb begin
        any_bad_s = 1'b0;
        for (int i = 0; i < int'(NDIG); i++) begin
            any_bad_s = any_bad_s | ~is_bcd(bus.bcd_in[i*DIGIT_W +: DIGIT_W]);
        end
    end

    // Next-state, datapath and output decode; every target holds by default.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        err_pend_d = err_pend_q;
        bin_out_d  = bin_out_q;
        err_d      = err_q;
        valid_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sr_d    = bus.bcd_in;
                    acc_d   = {BW{1'b0}};
                    idx_d   = {IDX_W{1'b0}};
                    state_d = CONV;
                    if (any_bad_s) begin
                        // Illegal digit: one flush cycle, then report. This
                        // keeps the error result on the same registered
                        // timing as a legal single-digit conversion.
                        err_pend_d = 1'b1;
                    end else begin
                        err_pend_d = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            CONV: begin
                if (err_pend_q) begin
                    state_d   = DONE;
                    bin_out_d = {BW{1'b0}};
                    err_d     = 1'b1;
                    valid_d   = 1'b1;
                end else begin
                    acc_d = step_sum_s;
                    sr_d  = sr_q << DIGIT_W;
                    if (idx_q == LAST_IDX) begin
                        // Last digit: the result lands in bin_out on the
                        // same edge that it lands in the accumulator.
                        idx_d     = {IDX_W{1'b0}};
                        state_d   = DONE;
                        bin_out_d = step_sum_s;
                        err_d     = 1'b0;
                        valid_d   = 1'b1;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = CONV;
                    end
                end
            end

            DONE: begin
                // Requests arriving here are dropped, not queued.
                state_d    = IDLE;
                err_pend_d = 1'b0;
            end

            default: begin
                state_d    = IDLE;
                err_pend_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous, dominant reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sr_q       <= {SR_W{1'b0}};
            acc_q      <= {BW{1'b0}};
            idx_q      <= {IDX_W{1'b0}};
            err_pend_q <= 1'b0;
            bin_out_q  <= {BW{1'b0}};
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            err_pend_q <= err_pend_d;
            bin_out_q  <= bin_out_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.bin_out = bin_out_q;
    assign bus.err     = err_q;
    assign bus.valid   = valid_q;
    assign bus.busy    = busy_q;

endmodule : bcd_to_bin_converter

// File: tb/tb_bcd_to_bin_converter.sv
// Self-checking bench for bcd_to_bin_converter: a vector table plus a
// results scoreboard, followed by hand-written handshake corner cases.
module tb_bcd_to_bin_converter;

    localparam int NDIG    = 4;
    localparam int BW      = 14;
    localparam int LAT_OK  = NDIG + 1;   // negedges from the start edge to valid
    localparam int LAT_ERR = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bcd_to_bin_converter_if #(.NDIG(NDIG), .BW(BW)) bus ();

    bcd_to_bin_converter #(.NDIG(NDIG), .BW(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [15:0]   bcd;
        logic [BW-1:0] exp_bin;
        logic          exp_err;
    } vec_t;

    typedef struct {
        logic [BW-1:0] bin;
        logic          err;
    } exp_t;

    vec_t vecs [12];
    exp_t sb_q [$];
    exp_t sb_e;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference conversion by positional weights (units digit at the bottom).
    function automatic logic [BW-1:0] bcd_model(input logic [15:0] b);
        int v = 0;
        int w = 1;
        for (int i = 0; i < NDIG; i++) begin
            v = v + int'(b[i*4 +: 4]) * w;
            w = w * 10;
        end
        return BW'(v);
    endfunction

    // Scoreboard: every valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected_valid: got valid with bin_out %0d, required no pending result", bus.bin_out);
            end else begin
                sb_e = sb_q.pop_front();
                check("sb_bin_out", 32'(bus.bin_out), 32'(sb_e.bin));
                check("sb_err", 32'(bus.err), 32'(sb_e.err));
            end
        end
    end

    // One pulsed conversion from IDLE; checks latency, busy span and return to idle.
    task automatic convert(input logic [15:0] bcd, input logic [BW-1:0] eb, input logic ee, input string tag);
        exp_t e;
        int   lat;
        int   busy_cnt;
        bit   seen;
        e.bin = eb;
        e.err = ee;
        sb_q.push_back(e);
        bus.start  = 1'b1;
        bus.bcd_in = bcd;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.bcd_in = 16'($urandom());
        seen = 1'b0;
        lat = 0;
        busy_cnt = 0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.valid === 1'b1) begin
                seen = 1'b1;
                lat = n;
            end
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no valid in 20 cycles, required valid", tag);
        end else begin
            check({tag, "_latency"}, 32'(lat), 32'(ee ? LAT_ERR : LAT_OK));
            check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(ee ? 2 : NDIG + 1));
            @(negedge clk);
            check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] b;
        logic [12:0] vh;

        vecs[0]  = '{16'h1234, 14'd1234, 1'b0};
        vecs[1]  = '{16'h9999, 14'd9999, 1'b0};
        vecs[2]  = '{16'h0000, 14'd0,    1'b0};
        vecs[3]  = '{16'h12A4, 14'd0,    1'b1};
        vecs[4]  = '{16'h0007, 14'd7,    1'b0};
        vecs[5]  = '{16'h0500, 14'd500,  1'b0};
        vecs[6]  = '{16'h4321, 14'd4321, 1'b0};
        vecs[7]  = '{16'h0001, 14'd1,    1'b0};
        vecs[8]  = '{16'h9000, 14'd9000, 1'b0};
        vecs[9]  = '{16'hF000, 14'd0,    1'b1};
        vecs[10] = '{16'h000A, 14'd0,    1'b1};
        vecs[11] = '{16'h0909, 14'd909,  1'b0};

        // Reset state.
        bus.start  = 1'b0;
        bus.bcd_in = 16'h0000;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bin_out", 32'(bus.bin_out), 32'd0);
        check("rst_valid",   32'(bus.valid),   32'd0);
        check("rst_busy",    32'(bus.busy),    32'd0);
        check("rst_err",     32'(bus.err),     32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table-driven conversions.
        for (int i = 0; i < 12; i++) begin
            convert(vecs[i].bcd, vecs[i].exp_bin, vecs[i].exp_err, "table");
        end

        // Random legal operands against the positional model.
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < NDIG; k++) b[k*4 +: 4] = 4'($urandom_range(0, 9));
            convert(b, bcd_model(b), 1'b0, "rand");
        end

        // Start held high: 9999 then 0000, valids six cycles apart.
        sb_q.push_back('{14'd9999, 1'b0});
        sb_q.push_back('{14'd0, 1'b0});
        bus.start  = 1'b1;
        bus.bcd_in = 16'h9999;
        @(posedge clk);
        #1;
        bus.bcd_in = 16'h0000;
        vh = '0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            vh[n] = bus.valid;
            @(posedge clk);
            #1;
            if (n == 6) bus.start = 1'b0;
        end
        check("b2b_valid_pattern", 32'(vh), 32'((13'd1 << 5) | (13'd1 << 11)));

        // Start pulses during CONV and DONE are ignored.
        sb_q.push_back('{14'd500, 1'b0});
        bus.start  = 1'b1;
        bus.bcd_in = 16'h0500;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        vh = '0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            vh[n] = bus.valid;
            @(posedge clk);
            #1;
            if (n <= 4) begin
                bus.start  = 1'b1;
                bus.bcd_in = 16'h9999;
            end else begin
                bus.start = 1'b0;
            end
        end
        check("busy_start_ignored", 32'(vh), 32'(13'd1 << 5));

        // Reset in the second CONV cycle discards the conversion.
        bus.start  = 1'b1;
        bus.bcd_in = 16'h4321;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midrst_bin_out", 32'(bus.bin_out), 32'd0);
        check("midrst_busy",    32'(bus.busy),    32'd0);
        check("midrst_valid",   32'(bus.valid),   32'd0);
        check("midrst_err",     32'(bus.err),     32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        convert(16'h4321, 14'd4321, 1'b0, "after_rst");

        // Result holds through a long idle with the digit inputs toggling.
        convert(16'h1234, 14'd1234, 1'b0, "hold_setup");
        for (int n = 0; n < 100; n++) begin
            bus.bcd_in = 16'($urandom());
            @(negedge clk);
            check("hold_bin_out", 32'(bus.bin_out), 32'd1234);
            check("hold_valid",   32'(bus.valid),   32'd0);
            @(posedge clk);
            #1;
        end

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Run-time bound in case the design never answers.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "time limit reached");
    end

endmodule : tb_bcd_to_bin_converter
